divide_controller: RTL and testbench
====================================

# divide_controller

Sequencing FSM for the calculator's restoring divider. Latches an unsigned dividend and divisor and drives the external (WIDTH+1)-bit remainder shift register through its load, shift-left and shift-right controls. Compares the register's output against the divisor each bit and builds the quotient internally. Sits between the calculator's operation decoder (start/done handshake) and the remainder shift register datapath.

## Interface
- WIDTH, 4, operand width; the remainder register is WIDTH+1 bits (5 by default)
- CLK  in  1  clock; all logic on the rising edge
- RST  in  1  synchronous, active-high reset; also wired to the remainder register's RST
- start  in  1  request a division; sampled only in IDLE
- dividend  in  WIDTH  unsigned dividend; sampled with start
- divisor  in  WIDTH  unsigned divisor; sampled with start
- rem_q  in  WIDTH+1  remainder register output Q
- rem_ld  out  1  remainder register LD
- rem_sl  out  1  remainder register SL
- rem_sr  out  1  remainder register SR; held 0
- rem_left_in  out  1  remainder register LeftIn; the next dividend bit, MSB first
- rem_d  out  WIDTH+1  remainder register D
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; quotient and remainder valid
- quotient  out  WIDTH  registered quotient; held until the next accepted start
- remainder  out  WIDTH  rem_q[WIDTH-1:0]; stable from DONE until the next CLEAR
- div_by_zero  out  1  registered flag; set at DONE when divisor was 0, cleared on the next accepted start

## Operation
- States: IDLE, CLEAR, SHIFT, TEST, DONE.
- IDLE: if start=1, latch dividend and divisor, clear quotient, count and div_by_zero, then go to CLEAR. start is ignored in every other state.
- CLEAR: rem_ld=1 with rem_d=0, then go to SHIFT.
  - With DIV_ZERO_DETECT_EN and a latched divisor of 0: rem_d={0,dividend}, quotient is set to all ones, div_by_zero is set, and the FSM goes to DONE.
- SHIFT: rem_sl=1 and rem_left_in=dvd_reg[WIDTH-1]; the latched dividend shifts left by one. Then go to TEST.
- TEST: compare rem_q >= {1'b0,divisor} at WIDTH+1 bits.
  - If true: rem_ld=1 with rem_d=rem_q-{1'b0,divisor}, and shift 1 into the quotient LSB.
  - If false: shift 0 into the quotient LSB and leave rem_ld low.
  - If count==WIDTH-1, go to DONE; otherwise increment count and go to SHIFT.
- DONE: done=1, then go to IDLE.
- Control rules:
  - At most one of rem_ld and rem_sl is high in any cycle.
  - All rem_* controls are 0 in IDLE and DONE, so the register holds its value.
  - rem_d is 0 whenever rem_ld=0.
- Width: after a TEST the remainder is less than the divisor, so it fits in WIDTH bits; after a SHIFT it fits in WIDTH+1 bits. The subtraction never underflows when taken.
- Reset values: state=IDLE; busy, done, div_by_zero, rem_ld, rem_sl, rem_sr, rem_left_in = 0; rem_d=0; quotient=0; count=0.
- Reset mid-operation: the FSM returns to IDLE on that edge and the remainder register clears through the shared RST. No done pulse is issued.

## Timing
- Let E be the edge on which start is accepted. The FSM is in CLEAR after edge E.
- The FSM is in SHIFT after edge E+1+2i and in TEST after edge E+2+2i, for i=0..WIDTH-1.
- DONE after edge E+2WIDTH+1 (E+9 at WIDTH=4); IDLE after edge E+2WIDTH+2.
- Divide-by-zero with the macro: DONE after edge E+1.
- A new start can be accepted on the edge that enters IDLE+1, i.e. while in IDLE. Back-to-back divisions therefore have a period of 2WIDTH+3 cycles.
- start held high continuously retriggers once per pass through IDLE.

## Configuration
- DIV_ZERO_DETECT_EN defined: a zero divisor takes the CLEAR→DONE fast path in 2 cycles, with quotient all ones, remainder=dividend and div_by_zero=1.
- Undefined: a zero divisor runs the normal 2WIDTH+2-cycle sequence, which naturally yields quotient all ones and remainder=dividend. div_by_zero is tied 0.

## Test plan
- start with 13/3 -> done after E+9, quotient=4, remainder=1, busy high after E through E+9.
- 15/1 -> quotient=15, remainder=0; 5/7 -> quotient=0, remainder=5. The bench checks every cycle that rem_ld and rem_sl are never both high and that rem_sr stays 0.
- 9/0 with DIV_ZERO_DETECT_EN -> done after E+1, quotient=15, remainder=9, div_by_zero=1. Without the macro -> done after E+9, quotient=15, remainder=9, div_by_zero=0.
- start 13/3, assert RST for one cycle after E+4 -> all outputs return to reset values and no done pulse. Then start 12/4 -> quotient=3, remainder=0.
- start 10/3, pulse start again with 7/1 at E+3 and at the DONE cycle -> both ignored; result quotient=3, remainder=1. The next start in IDLE with 7/1 -> quotient=7, remainder=0.

Source files
------------

// File: rtl/divide_controller_if.sv
// Signal bundle between divide_controller, the operation decoder (start/done)
// and the external (WIDTH+1)-bit remainder shift register.
interface divide_controller_if #(
  parameter int WIDTH = 4
);
  // Handshake: start is sampled only while busy=0. The edge that samples it high
  // latches dividend/divisor and raises busy. done pulses for exactly one cycle
  // when quotient/remainder/div_by_zero are valid. There is no backpressure.
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  logic [WIDTH:0]   rem_q;
  logic             rem_ld;
  logic             rem_sl;
  logic             rem_sr;
  logic             rem_left_in;
  logic [WIDTH:0]   rem_d;

  modport master (
    output start, dividend, divisor, rem_q,
    input  busy, done, quotient, remainder, div_by_zero,
           rem_ld, rem_sl, rem_sr, rem_left_in, rem_d
  );

  modport slave (
    input  start, dividend, divisor, rem_q,
    output busy, done, quotient, remainder, div_by_zero,
           rem_ld, rem_sl, rem_sr, rem_left_in, rem_d
  );
endinterface

// File: rtl/divide_controller.sv
// Restoring-divider sequencer driving an external remainder shift register.
// Optional macro DIV_ZERO_DETECT_EN: zero divisor short-circuits CLEAR -> DONE.
module divide_controller #(
  parameter int WIDTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  divide_controller_if.slave  div_if,
  output logic [2:0]          state_o
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_SHIFT = 3'd2,
      S_TEST  = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] quo_q, quo_d;
`ifdef DIV_ZERO_DETECT_EN
   logic             dbz_q, dbz_d;
`endif

   logic             rem_ld;
   logic             rem_sl;
   logic             rem_left_in;
   logic [WIDTH:0]   rem_d;
   logic [WIDTH:0]   dvs_ext;
   logic [WIDTH:0]   rem_diff;
   logic             rem_ge;

   assign dvs_ext  = {1'b0, dvs_q};
   assign rem_ge   = (div_if.rem_q >= dvs_ext);
   assign rem_diff = div_if.rem_q - dvs_ext;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         quo_q   <= '0;
`ifdef DIV_ZERO_DETECT_EN
         dbz_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         quo_q   <= quo_d;
`ifdef DIV_ZERO_DETECT_EN
         dbz_q   <= dbz_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      dvd_d       = dvd_q;
      dvs_d       = dvs_q;
      quo_d       = quo_q;
`ifdef DIV_ZERO_DETECT_EN
      dbz_d       = dbz_q;
`endif
      rem_ld      = 1'b0;
      rem_sl      = 1'b0;
      rem_left_in = 1'b0;
      rem_d       = '0;

      case (state_q)
         S_IDLE: begin
            if (div_if.start) begin
               dvd_d   = div_if.dividend;
               dvs_d   = div_if.divisor;
               quo_d   = '0;
               cnt_d   = '0;
`ifdef DIV_ZERO_DETECT_EN
               dbz_d   = 1'b0;
`endif
               state_d = S_CLEAR;
            end
         end

         S_CLEAR: begin
            rem_ld  = 1'b1;
            state_d = S_SHIFT;
`ifdef DIV_ZERO_DETECT_EN
            // Load the dividend straight in as the remainder and skip the loop.
            if (dvs_q == '0) begin
               rem_d   = {1'b0, dvd_q};
               quo_d   = '1;
               dbz_d   = 1'b1;
               state_d = S_DONE;
            end
`endif
         end

         S_SHIFT: begin
            rem_sl      = 1'b1;
            rem_left_in = dvd_q[WIDTH-1];
            dvd_d       = {dvd_q[WIDTH-2:0], 1'b0};
            state_d     = S_TEST;
         end

         S_TEST: begin
            // Restore is implicit: on a failed compare the register just holds.
            if (rem_ge) begin
               rem_ld = 1'b1;
               rem_d  = rem_diff;
            end
            quo_d = {quo_q[WIDTH-2:0], rem_ge};
            if (cnt_q == LAST_CNT) begin
               state_d = S_DONE;
            end else begin
               cnt_d   = cnt_q + CW'(1);
               state_d = S_SHIFT;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign div_if.rem_ld      = rem_ld;
   assign div_if.rem_sl      = rem_sl;
   assign div_if.rem_sr      = 1'b0;
   assign div_if.rem_left_in = rem_left_in;
   assign div_if.rem_d       = rem_d;
   assign div_if.busy        = (state_q != S_IDLE);
   assign div_if.done        = (state_q == S_DONE);
   assign div_if.quotient    = quo_q;
   assign div_if.remainder   = div_if.rem_q[WIDTH-1:0];
`ifdef DIV_ZERO_DETECT_EN
   assign div_if.div_by_zero = dbz_q;
`else
   assign div_if.div_by_zero = 1'b0;
`endif
   assign state_o            = state_q;

endmodule

// File: tb/tb_divide_controller.sv
// Bench for divide_controller with a behavioural remainder shift register,
// an expected-result queue and a done-driven monitor.
module tb_divide_controller;
  localparam int W  = 4;
  localparam int EW = 32 + 1 + 2 * W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  divide_controller_if #(.WIDTH(W)) dif ();
  logic [2:0] state_dbg;

  divide_controller #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .div_if  (dif.slave),
    .state_o (state_dbg)
  );

  // Remainder shift register model: RST > LD > SL > SR.
  logic [W:0] rem_reg;
  always_ff @(posedge clk) begin
    if (rst)             rem_reg <= '0;
    else if (dif.rem_ld) rem_reg <= dif.rem_d;
    else if (dif.rem_sl) rem_reg <= {rem_reg[W-1:0], dif.rem_left_in};
    else if (dif.rem_sr) rem_reg <= {1'b0, rem_reg[W:1]};
  end
  assign dif.rem_q = rem_reg;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse retires the oldest expected result.
  always @(negedge clk) begin
    if (dif.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1, expected no result pending (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("done_cycle",  cyc,             mon_e[EW-1 -: 32]);
        check("div_by_zero", dif.div_by_zero, {31'd0, mon_e[2*W]});
        check("quotient",    dif.quotient,    {28'd0, mon_e[2*W-1 -: W]});
        check("remainder",   dif.remainder,   {28'd0, mon_e[W-1:0]});
      end
    end
  end

  // Register control rules, checked every cycle.
  always @(negedge clk) begin
    n_vec++;
    if ((dif.rem_ld && dif.rem_sl) || dif.rem_sr !== 1'b0 || (!dif.rem_ld && dif.rem_d !== '0)) begin
      n_err++;
      $display("FAIL rem_ctrl: got ld=%b sl=%b sr=%b d=%0d, expected ld&sl=0 sr=0 d=0 when !ld (cycle %0d)",
               dif.rem_ld, dif.rem_sl, dif.rem_sr, dif.rem_d, cyc);
    end
  end

  // Drive one start at a negedge; returns at the negedge after the accepting edge E.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                       input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
    int e_cyc;
    dif.start    = 1'b1;
    dif.dividend = a;
    dif.divisor  = b;
    @(posedge clk);
    #1;
    e_cyc = cyc;
    exp_q.push_back({32'(e_cyc + lat), z, q, r});
    @(negedge clk);
    dif.start = 1'b0;
  endtask

  // busy must be high from E through E+lat and low one cycle later.
  task automatic follow(input int lat);
    for (int k = 0; k <= lat; k++) begin
      check("busy_run", dif.busy, 1);
      @(negedge clk);
    end
    check("busy_idle", dif.busy, 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"},  dif.busy, 0);
    check({tag, "_done"},  dif.done, 0);
    check({tag, "_quo"},   dif.quotient, 0);
    check({tag, "_rem"},   dif.remainder, 0);
    check({tag, "_dbz"},   dif.div_by_zero, 0);
    check({tag, "_ctl"},   {dif.rem_ld, dif.rem_sl, dif.rem_sr, dif.rem_left_in}, 0);
    check({tag, "_remd"},  dif.rem_d, 0);
    check({tag, "_state"}, state_dbg, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no end of test, expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    dif.start    = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);

    // 13/3 -> 4 r1, result held while idle
    issue(4'd13, 4'd3, 9, 4'd4, 4'd1, 1'b0);
    follow(9);
    repeat (3) @(negedge clk);
    check("hold_quo", dif.quotient, 4);
    check("hold_rem", dif.remainder, 1);

    issue(4'd15, 4'd1, 9, 4'd15, 4'd0, 1'b0);
    follow(9);
    issue(4'd5, 4'd7, 9, 4'd0, 4'd5, 1'b0);
    follow(9);

`ifdef DIV_ZERO_DETECT_EN
    issue(4'd9, 4'd0, 1, 4'd15, 4'd9, 1'b1);
    follow(1);
`else
    issue(4'd9, 4'd0, 9, 4'd15, 4'd9, 1'b0);
    follow(9);
`endif

    // Reset in the middle of 13/3: no done, everything back to reset values.
    issue(4'd13, 4'd3, 9, 4'd4, 4'd1, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    void'(exp_q.pop_back());
    check_reset_state("midrst");
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("midrst_idle", dif.busy, 0);

    issue(4'd12, 4'd4, 9, 4'd3, 4'd0, 1'b0);
    follow(9);

    // 10/3 with stray starts at E+3 and in the DONE cycle.
    issue(4'd10, 4'd3, 9, 4'd3, 4'd1, 1'b0);
    repeat (2) @(negedge clk);
    dif.start = 1'b1; dif.dividend = 4'd7; dif.divisor = 4'd1;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (6) @(negedge clk);
    check("ign_done_cycle", dif.done, 1);
    dif.start = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    check("ign_idle", dif.busy, 0);

    issue(4'd7, 4'd1, 9, 4'd7, 4'd0, 1'b0);
    follow(9);

    repeat (2) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL pending_results: got %0d outstanding, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
